// File: rtl/branch_unit.sv
// Program-counter and branch-resolution unit.
// Resolves B/BL/BX/RET requests against the Z/N/V flags and keeps return
// addresses on a circular hardware stack. When the stack is full, a push
// overwrites the oldest entry. Stack overflow and underflow are reported
// through sticky error flags.
module branch_unit #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_en,
  input  logic                               br_valid,
  input  logic [1:0]                         br_kind,
  input  logic [2:0]                         br_cond,
  input  logic [DATA_WIDTH-1:0]              sximm8,
  input  logic [DATA_WIDTH-1:0]              reg_target,
  input  logic                               Z,
  input  logic                               N,
  input  logic                               V,
  input  logic                               err_clr,
  output logic [ADDR_WIDTH-1:0]              pc,
  output logic [ADDR_WIDTH-1:0]              link_out,
  output logic                               taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] KindB   = 2'b00;
  localparam logic [1:0] KindBl  = 2'b01;
  localparam logic [1:0] KindBx  = 2'b10;
  localparam logic [1:0] KindRet = 2'b11;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] link_q, link_d;
  logic                  taken_q, taken_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       head_q, head_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [PtrW-1:0]       head_inc;
  logic [PtrW-1:0]       head_dec;
  logic                  cond_met;
  logic                  push;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  is_full;
  logic                  is_empty;

  // Upper operand bits are intentionally dropped: addresses wrap modulo 2^ADDR_WIDTH.
  logic unused_hi;
  assign unused_hi = ^{sximm8[DATA_WIDTH-1:ADDR_WIDTH], reg_target[DATA_WIDTH-1:ADDR_WIDTH]};

  assign is_full  = (cnt_q == CntW'(STACK_DEPTH));
  assign is_empty = (cnt_q == '0);

  // Condition-code evaluation for B/BL.
  always_comb begin
    cond_met = 1'b0;
    unique case (br_cond)
      3'b000: cond_met = 1'b1;
      3'b001: cond_met = Z;
      3'b010: cond_met = ~Z;
      3'b011: cond_met = (N != V);
      3'b100: cond_met = (N != V) | Z;
      3'b101: cond_met = (N == V);
      3'b110: cond_met = (N == V) & ~Z;
      3'b111: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  end

  // head_q is the next free slot; the top entry sits one below it, modulo depth.
  always_comb begin
    head_inc = (head_q == PtrW'(STACK_DEPTH - 1)) ? '0 : head_q + PtrW'(1);
    head_dec = (head_q == '0) ? PtrW'(STACK_DEPTH - 1) : head_q - PtrW'(1);
  end

  // Next-state decode: br_valid has priority over pc_en, and hold is the default.
  always_comb begin
    seq     = pc_q + ADDR_WIDTH'(1);
    tgt     = seq + sximm8[ADDR_WIDTH-1:0];
    pc_d    = pc_q;
    link_d  = link_q;
    taken_d = 1'b0;
    cnt_d   = cnt_q;
    head_d  = head_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (br_valid) begin
      unique case (br_kind)
        KindB: begin
          pc_d    = cond_met ? tgt : seq;
          taken_d = cond_met;
        end
        KindBl: begin
          if (cond_met) begin
            pc_d    = tgt;
            link_d  = seq;
            taken_d = 1'b1;
            push    = 1'b1;
            head_d  = head_inc;
            // A full stack keeps its count; the push lands on the oldest slot.
            if (is_full) begin
              ovf_set = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            pc_d = seq;
          end
        end
        KindBx: begin
          pc_d    = reg_target[ADDR_WIDTH-1:0];
          taken_d = 1'b1;
        end
        KindRet: begin
          if (!is_empty) begin
            pc_d    = stack_mem[head_dec];
            head_d  = head_dec;
            cnt_d   = cnt_q - CntW'(1);
            taken_d = 1'b1;
          end else begin
            pc_d    = seq;
            unf_set = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end else if (pc_en) begin
      pc_d = seq;
    end
    // A new error event on the same edge wins over err_clr.
    ovf_d = (ovf_q & ~err_clr) | ovf_set;
    unf_d = (unf_q & ~err_clr) | unf_set;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
      link_q  <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stack_mem[head_q] <= seq;
    end
  end

  assign pc          = pc_q;
  assign link_out    = link_q;
  assign taken       = taken_q;
  assign stack_count = cnt_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised program-counter and branch-resolution unit for the next-generation RISC core.
- Replaces the fixed PC+1 / PC+1+sximm8 next-PC mux with the following:
  - eight branch conditions;
  - call/return support backed by a hardware return-address stack of configurable depth;
  - register-indirect jumps;
  - sticky stack-error reporting.
- Sits between the FSM controller (request strobes) and the memory address mux (pc output).

Parameters:
- ADDR_WIDTH, 9: width of pc, link_out and stack entries.
- DATA_WIDTH, 16: width of sximm8 and reg_target.
- STACK_DEPTH, 4: number of return-stack entries. Must be ≥1.
- RESET_VECTOR, 0: pc value after reset.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset (asserted when 0).
- pc_en, input, 1: advance pc by 1 this cycle when no branch request is present.
- br_valid, input, 1: branch request strobe, one cycle.
- br_kind, input, 2: branch type. 00 = B (conditional), 01 = BL (conditional call), 10 = BX (jump to reg_target), 11 = RET (pop stack).
- br_cond, input, 3: condition code, used by B/BL only.
- sximm8, input, DATA_WIDTH: sign-extended branch offset.
- reg_target, input, DATA_WIDTH: register operand for BX.
- Z, input, 1: zero status flag from the datapath.
- N, input, 1: negative status flag from the datapath.
- V, input, 1: overflow status flag from the datapath.
- err_clr, input, 1: clears the sticky error flags.
- pc, output, ADDR_WIDTH: current program counter.
- link_out, output, ADDR_WIDTH: return address captured by the last taken BL.
- taken, output, 1: registered; 1 for the cycle after a request that redirected pc.
- stack_count, output, $clog2(STACK_DEPTH+1): number of valid stack entries.
- stack_full, output, 1: stack_count == STACK_DEPTH.
- stack_empty, output, 1: stack_count == 0.
- ovf_err, output, 1: sticky overflow flag.
- unf_err, output, 1: sticky underflow flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc = RESET_VECTOR.
  - link_out, taken, stack_count, ovf_err, unf_err = 0.
  - Stack contents are don't-care.
  - Reset has priority over every other input.
- Priority each cycle: reset > br_valid > pc_en > hold.
  - A br_valid request ignores pc_en; an untaken branch still advances pc by 1.
- Arithmetic:
  - seq = pc + 1.
  - tgt = pc + 1 + sximm8[ADDR_WIDTH-1:0].
  - Both are truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH wrap; no error).
- Condition evaluation for B/BL, using Z/N/V sampled in the request cycle:
  - 000: always.
  - 001: EQ (Z).
  - 010: NE (!Z).
  - 011: LT (N!=V).
  - 100: LE (N!=V | Z).
  - 101: GE (N==V).
  - 110: GT (N==V & !Z).
  - 111: never.
- B:
  - pc <= cond ? tgt : seq.
  - taken <= cond.
- BL:
  - If cond: pc <= tgt; link_out <= seq; push seq; taken <= 1.
  - If not cond: pc <= seq; no push; taken <= 0.
- BX: pc <= reg_target[ADDR_WIDTH-1:0]; taken <= 1; stack untouched.
- RET:
  - Non-empty stack: pc <= top entry; pop; taken <= 1.
  - Empty stack: pc <= seq; unf_err <= 1; taken <= 0; stack_count stays 0.
- Push when full:
  - Oldest entry is discarded (circular overwrite).
  - New entry becomes top.
  - stack_count stays STACK_DEPTH.
  - ovf_err <= 1.
  - A subsequent RET returns the newest entry (LIFO preserved for the retained entries).
- taken returns to 0 on any cycle without a taken request.
- Error flags:
  - Sticky until err_clr==1, which clears them at the next edge.
  - If err_clr coincides with a new error event, the flag stays set.
- stack_full and stack_empty are combinational from stack_count.
- Hold: with no request and pc_en==0, all state is held.
- Reset mid-sequence discards the stack contents and any pending taken indication.

Test Plan:
- Reset with RESET_VECTOR=0, then pc_en for 3 cycles → pc=3; taken=0; stack_empty=1.
- pc=10, B cond=001, Z=1, sximm8=0xFFFB (−5) → next pc=6, taken=1. Repeat with Z=0 → pc=11, taken=0.
- pc=0x1FE, B cond=000, sximm8=4 → pc=0x003 (wrap), no error flag.
- pc=20, BL cond=000, sximm8=5 → pc=26, link_out=21, stack_count=1. Then RET → pc=21, stack_count=0, taken=1.
- Five BLs with STACK_DEPTH=4, from pcs 1, 11, 21, 31, 41 (pushing 2, 12, 22, 32, 42) → stack_count=4, ovf_err=1. Four RETs → pcs 42, 32, 22, 12. Fifth RET → pc=prev+1, unf_err=1. Then err_clr → both flags 0.
- BX with reg_target=0x0123 and pc_en=1 in the same cycle → pc=0x123, taken=1. Then reset=0 mid-call chain (stack_count=2) → pc=0, stack_count=0, link_out=0.
